// File: rtl/scope_pkg.sv
// Shared definitions for the ADC capture scope: sample width, FSM states
// and the edge-trigger rule used while armed.
package scope_pkg;

   localparam int ADC_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PRE   = 3'd1,
      ST_ARMED = 3'd2,
      ST_POST  = 3'd3,
      ST_READ  = 3'd4
   } state_t;

   function automatic logic trig_hit(input logic             rising,
                                     input logic [ADC_W-1:0] level,
                                     input logic [ADC_W-1:0] prev,
                                     input logic [ADC_W-1:0] cur);
      if (rising) begin
         return (prev < level) && (cur >= level);
      end else begin
         return (prev >= level) && (cur < level);
      end
   endfunction

endpackage

// File: rtl/scope_sample_ram.sv
// DEPTH x ADC_W simple dual-port sample RAM, one write port and one
// registered read port with read enable, shaped to map onto block RAM.
module scope_sample_ram
   import scope_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [ADC_W-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [ADC_W-1:0] rdata
);

   logic [ADC_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // read data holds while re is low so a stalled reader sees a stable word
   always_ff @(posedge clk) begin
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/adc_capture.sv
// Triggered ADC capture: generates the ADC conversion clock, records a ring of
// samples around a level-crossing trigger and streams them out oldest first.
module adc_capture
   import scope_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int DEPTH    = 256,
   parameter int PRE_TRIG = 64
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [ADC_W-1:0] ADC_D,
   output logic             ADC_CLK,
   output logic             ADC_nOE,
   input  logic             ARM,
   input  logic [ADC_W-1:0] TRIG_LEVEL,
   input  logic             TRIG_RISING,
   output logic             BUSY,
   output logic             DONE,
   output logic             RD_VALID,
   input  logic             RD_READY,
   output logic [ADC_W-1:0] RD_DATA,
   output logic             RD_LAST
);

   localparam int AW     = $clog2(DEPTH);
   localparam int DW     = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int CW     = AW + 1;
   localparam int POST_N = DEPTH - PRE_TRIG;

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
   localparam logic [CW-1:0] PRE_END  = CW'(PRE_TRIG - 1);
   localparam logic [CW-1:0] POST_END = CW'(POST_N - 1);
   localparam logic [CW-1:0] RD_END   = CW'(DEPTH - 1);
   localparam logic [CW-1:0] RD_CNT   = CW'(DEPTH);
   localparam logic [AW-1:0] PRE_OFS  = AW'(PRE_TRIG);

   state_t           state;
   state_t           nxt;
   logic [DW-1:0]    div_cnt;
   logic             strobe;
   logic             capt;
   logic             hit;
   logic             xfer_last;
   logic [AW-1:0]    wr_addr;
   logic [AW-1:0]    trig_addr;
   logic [CW-1:0]    samp_cnt;
   logic             have_prev;
   logic [ADC_W-1:0] prev_smp;
   logic [CW-1:0]    rd_idx;
   logic [AW-1:0]    rd_base;
   logic [AW-1:0]    rd_addr;
   logic             ram_vld;
   logic             ram_last;
   logic             load;
   logic             issue;
   logic [ADC_W-1:0] ram_rdata;

   assign strobe    = (div_cnt == DIV_LAST);
   assign ADC_CLK   = !RST && (div_cnt < DIV_HALF);
   assign capt      = (state == ST_PRE) || (state == ST_ARMED) || (state == ST_POST);
   assign hit       = (state == ST_ARMED) && strobe && have_prev &&
                      trig_hit(TRIG_RISING, TRIG_LEVEL, prev_smp, ADC_D);
   assign xfer_last = RD_VALID && RD_READY && RD_LAST;

   // free-running conversion clock divider
   always_ff @(posedge CLK) begin
      if (RST) begin
         div_cnt <= '0;
      end else if (strobe) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DW'(1);
      end
   end

   // FSM state register
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= ST_IDLE;
      end else begin
         state <= nxt;
      end
   end

   // FSM next-state logic
   always_comb begin
      nxt = state;
      case (state)
         ST_IDLE: begin
            if (ARM) begin
               nxt = (PRE_TRIG == 0) ? ST_ARMED : ST_PRE;
            end else begin
               nxt = ST_IDLE;
            end
         end
         ST_PRE: begin
            if (strobe && (samp_cnt == PRE_END)) begin
               nxt = ST_ARMED;
            end else begin
               nxt = ST_PRE;
            end
         end
         ST_ARMED: begin
            if (hit) begin
               nxt = (POST_N == 1) ? ST_READ : ST_POST;
            end else begin
               nxt = ST_ARMED;
            end
         end
         ST_POST: begin
            if (strobe && (samp_cnt == POST_END)) begin
               nxt = ST_READ;
            end else begin
               nxt = ST_POST;
            end
         end
         ST_READ: begin
            if (xfer_last) begin
               nxt = ST_IDLE;
            end else begin
               nxt = ST_READ;
            end
         end
         default: nxt = ST_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      ADC_nOE = 1'b1;
      BUSY    = 1'b1;
      case (state)
         ST_IDLE:                  BUSY    = 1'b0;
         ST_PRE, ST_ARMED, ST_POST: ADC_nOE = 1'b0;
         ST_READ:                  ADC_nOE = 1'b1;
         default: begin
            ADC_nOE = 1'b1;
            BUSY    = 1'b0;
         end
      endcase
   end

   // capture bookkeeping: ring write pointer, phase sample count, trigger point
   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_addr   <= '0;
         trig_addr <= '0;
         samp_cnt  <= '0;
         have_prev <= 1'b0;
         prev_smp  <= '0;
      end else begin
         if (capt && strobe) begin
            wr_addr   <= wr_addr + AW'(1);
            prev_smp  <= ADC_D;
            have_prev <= 1'b1;
         end
         case (state)
            ST_IDLE: begin
               samp_cnt  <= '0;
               have_prev <= 1'b0;
            end
            ST_PRE, ST_POST: begin
               if (strobe) begin
                  samp_cnt <= samp_cnt + CW'(1);
               end
            end
            ST_ARMED: begin
               // the trigger sample is the first post-trigger sample
               if (hit) begin
                  trig_addr <= wr_addr;
                  samp_cnt  <= CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   scope_sample_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (CLK),
      .we    (capt && strobe),
      .waddr (wr_addr),
      .wdata (ADC_D),
      .re    (issue),
      .raddr (rd_addr),
      .rdata (ram_rdata)
   );

   // RAM read stage feeds the output register; a read is only issued when the
   // word already held at the RAM output can move on in the same cycle
   assign rd_base = trig_addr - PRE_OFS;
   assign rd_addr = rd_base + rd_idx[AW-1:0];
   assign load    = ram_vld && (!RD_VALID || RD_READY);
   assign issue   = (state == ST_READ) && (rd_idx != RD_CNT) && (!ram_vld || load);

   // read address sequencing and RAM-output valid tracking
   always_ff @(posedge CLK) begin
      if (RST || (state != ST_READ)) begin
         rd_idx   <= '0;
         ram_vld  <= 1'b0;
         ram_last <= 1'b0;
      end else begin
         if (issue) begin
            rd_idx   <= rd_idx + CW'(1);
            ram_last <= (rd_idx == RD_END);
            ram_vld  <= 1'b1;
         end else if (load) begin
            ram_vld  <= 1'b0;
         end
      end
   end

   // readout stream output register
   always_ff @(posedge CLK) begin
      if (RST) begin
         RD_VALID <= 1'b0;
         RD_DATA  <= '0;
         RD_LAST  <= 1'b0;
      end else if (state != ST_READ) begin
         RD_VALID <= 1'b0;
         RD_LAST  <= 1'b0;
      end else if (load) begin
         RD_VALID <= 1'b1;
         RD_DATA  <= ram_rdata;
         RD_LAST  <= ram_last;
      end else if (RD_READY) begin
         RD_VALID <= 1'b0;
         RD_LAST  <= 1'b0;
      end
   end

   // completion pulse, one cycle after the final word is accepted
   always_ff @(posedge CLK) begin
      if (RST) begin
         DONE <= 1'b0;
      end else begin
         DONE <= xfer_last;
      end
   end

endmodule

// File: tb/tb_adc_capture.sv
// Self-checking bench for adc_capture: randomized captures compared against a
// queue-based model of which samples the readout must return.
module tb_adc_capture;

   localparam int CLK_DIV  = 4;
   localparam int DEPTH    = 16;
   localparam int PRE_TRIG = 4;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [7:0] ADC_D = 8'h00;
   logic       ADC_CLK, ADC_nOE, BUSY, DONE, RD_VALID, RD_LAST;
   logic       ARM = 1'b0;
   logic [7:0] TRIG_LEVEL = 8'h80;
   logic       TRIG_RISING = 1'b1;
   logic       RD_READY = 1'b1;
   logic [7:0] RD_DATA;

   always #5 CLK = ~CLK;

   adc_capture #(.CLK_DIV(CLK_DIV), .DEPTH(DEPTH), .PRE_TRIG(PRE_TRIG)) dut (
      .CLK(CLK), .RST(RST), .ADC_D(ADC_D), .ADC_CLK(ADC_CLK), .ADC_nOE(ADC_nOE),
      .ARM(ARM), .TRIG_LEVEL(TRIG_LEVEL), .TRIG_RISING(TRIG_RISING), .BUSY(BUSY),
      .DONE(DONE), .RD_VALID(RD_VALID), .RD_READY(RD_READY), .RD_DATA(RD_DATA),
      .RD_LAST(RD_LAST)
   );

   int         tests = 0;
   int         fails = 0;
   int         mdiv = 0;
   bit         capturing = 1'b0;
   bit         rnd_ready = 1'b0;
   int         mode = 0;
   logic [7:0] gen_val = 8'h00;
   int         gen_step = 0;
   logic [7:0] cap_q[$];
   logic [8:0] rx_q[$];
   bit         stall_pend = 1'b0;
   logic [7:0] held_d;
   logic       held_l;
   bit         done_seen = 1'b0;
   int         read_age = 0;
   int         lat = -1;

   // one clock: record strobed samples and transfers, then check per-cycle rules
   task automatic tick();
      bit stb, xl, exp_clk;
      stb = !RST && (mdiv == CLK_DIV - 1);
      if (stb && capturing) cap_q.push_back(ADC_D);
      xl = !RST && (RD_VALID === 1'b1) && (RD_READY === 1'b1) && (RD_LAST === 1'b1);
      if (!RST && RD_VALID === 1'b1 && RD_READY === 1'b1) rx_q.push_back({RD_LAST, RD_DATA});
      if (stall_pend && !RST) begin
         tests++;
         if (RD_VALID !== 1'b1 || RD_DATA !== held_d || RD_LAST !== held_l) begin
            fails++;
            $display("FAIL stall_hold got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                     RD_VALID, RD_DATA, RD_LAST, held_d, held_l);
         end
      end
      stall_pend = !RST && (RD_VALID === 1'b1) && (RD_READY === 1'b0);
      held_d = RD_DATA;
      held_l = RD_LAST;
      @(posedge CLK);
      mdiv = RST ? 0 : (mdiv + 1) % CLK_DIV;
      #1;
      if (stb && capturing) begin
         case (mode)
            0: gen_val = gen_val + 8'(gen_step);
            1: gen_val = gen_val;
            default: gen_val = 8'($urandom_range(0, 255));
         endcase
         ADC_D = gen_val;
      end
      tests++;
      if (DONE !== xl) begin
         fails++;
         $display("FAIL done_pulse got=%b exp=%b", DONE, xl);
      end
      if (DONE === 1'b1) done_seen = 1'b1;
      exp_clk = !RST && (mdiv < CLK_DIV / 2);
      tests++;
      if (ADC_CLK !== exp_clk) begin
         fails++;
         $display("FAIL adc_clk got=%b exp=%b (phase %0d)", ADC_CLK, exp_clk, mdiv);
      end
      if (BUSY === 1'b1 && ADC_nOE === 1'b1) begin
         if (RD_VALID === 1'b1 && lat < 0) lat = read_age;
         read_age++;
      end else begin
         read_age = 0;
      end
      if (rnd_ready) RD_READY = 1'($urandom_range(0, 1));
   endtask

   // model: find the first qualifying crossing and expect the DEPTH samples around it
   task automatic check_readout(input string name, input int exp4);
      int k;
      bit c;
      k = -1;
      for (int i = (PRE_TRIG > 0 ? PRE_TRIG : 1); i < cap_q.size(); i++) begin
         if (TRIG_RISING) c = (cap_q[i-1] < TRIG_LEVEL) && (cap_q[i] >= TRIG_LEVEL);
         else             c = (cap_q[i-1] >= TRIG_LEVEL) && (cap_q[i] < TRIG_LEVEL);
         if (c && k < 0) k = i;
      end
      tests++;
      if (k < 0 || k + DEPTH - PRE_TRIG > cap_q.size()) begin
         fails++;
         $display("FAIL %s_trigger got k=%0d samples=%0d exp a complete capture", name, k, cap_q.size());
         return;
      end
      tests++;
      if (rx_q.size() != DEPTH) begin
         fails++;
         $display("FAIL %s_count got=%0d exp=%0d", name, rx_q.size(), DEPTH);
      end
      for (int i = 0; i < DEPTH && i < rx_q.size(); i++) begin
         logic [8:0] e;
         e = {(i == DEPTH - 1), cap_q[k - PRE_TRIG + i]};
         tests++;
         if (rx_q[i] !== e) begin
            fails++;
            $display("FAIL %s_word%0d got last=%b d=%h exp last=%b d=%h",
                     name, i, rx_q[i][8], rx_q[i][7:0], e[8], e[7:0]);
         end
      end
      if (exp4 >= 0 && rx_q.size() > 4) begin
         tests++;
         if (rx_q[4][7:0] !== 8'(exp4)) begin
            fails++;
            $display("FAIL %s_index4 got=%h exp=%h", name, rx_q[4][7:0], 8'(exp4));
         end
      end
   endtask

   task automatic start_capture(input logic [7:0] start, input int step, input int md,
                                input bit rising);
      TRIG_RISING = rising;
      mode = md;
      gen_step = step;
      gen_val = (md == 2) ? 8'($urandom_range(0, 255)) : start;
      ADC_D = gen_val;
      cap_q.delete();
      rx_q.delete();
      done_seen = 1'b0;
      lat = -1;
      ARM = 1'b1;
      tick();
      ARM = 1'b0;
      capturing = 1'b1;
      tests++;
      if (BUSY !== 1'b1 || ADC_nOE !== 1'b0) begin
         fails++;
         $display("FAIL arm_accept got busy=%b noe=%b exp busy=1 noe=0", BUSY, ADC_nOE);
      end
   endtask

   task automatic run_capture(input string name, input logic [7:0] start, input int step,
                              input int md, input bit rising, input bit rr, input int exp4);
      rnd_ready = rr;
      RD_READY = 1'b1;
      start_capture(start, step, md, rising);
      for (int n = 0; n < 4000 && !done_seen; n++) tick();
      capturing = 1'b0;
      rnd_ready = 1'b0;
      RD_READY = 1'b1;
      tests++;
      if (!done_seen) begin
         fails++;
         $display("FAIL %s_timeout got no DONE exp DONE within 4000 cycles", name);
      end
      check_readout(name, exp4);
      tests++;
      if (lat < 0 || lat > 2) begin
         fails++;
         $display("FAIL %s_read_latency got=%0d exp=0..2", name, lat);
      end
      tests++;
      if (BUSY !== 1'b0 || RD_VALID !== 1'b0 || ADC_nOE !== 1'b1) begin
         fails++;
         $display("FAIL %s_idle_after got busy=%b valid=%b noe=%b exp 0 0 1", name, BUSY, RD_VALID, ADC_nOE);
      end
   endtask

   task automatic check_idle_outputs(input string name, input bit full);
      tests++;
      if (BUSY !== 1'b0 || ADC_nOE !== 1'b1 || RD_VALID !== 1'b0 ||
          (full && (DONE !== 1'b0 || RD_DATA !== 8'h00 || RD_LAST !== 1'b0))) begin
         fails++;
         $display("FAIL %s got busy=%b noe=%b valid=%b done=%b data=%h last=%b exp 0 1 0 0 00 0",
                  name, BUSY, ADC_nOE, RD_VALID, DONE, RD_DATA, RD_LAST);
      end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_idle_outputs("reset_values", 1'b1);
      end
      RST = 1'b0;
      #1;
      tests++;
      if (ADC_CLK !== 1'b1) begin
         fails++;
         $display("FAIL adc_clk_release got=%b exp=1", ADC_CLK);
      end
      for (int i = 0; i < 8; i++) begin
         tick();
         check_idle_outputs("idle_after_release", 1'b0);
      end
   endtask

   task automatic test_ramp_rising();
      TRIG_LEVEL = 8'h80;
      run_capture("ramp_rise", 8'h70, 2, 0, 1'b1, 1'b0, 8'h80);
      tests++;
      if (rx_q.size() != DEPTH || rx_q[0] !== 9'h078 || rx_q[DEPTH-1] !== 9'h196) begin
         fails++;
         $display("FAIL ramp_rise_ends got first=%h last=%h exp 078 196",
                  rx_q.size() > 0 ? rx_q[0] : 9'h0, rx_q.size() > 0 ? rx_q[rx_q.size()-1] : 9'h0);
      end
   endtask

   task automatic test_ramp_falling();
      TRIG_LEVEL = 8'h80;
      run_capture("ramp_fall", 8'h90, -2, 0, 1'b0, 1'b0, 8'h7E);
   endtask

   task automatic test_backpressure();
      TRIG_LEVEL = 8'h80;
      run_capture("stall_ramp", 8'h70, 2, 0, 1'b1, 1'b1, 8'h80);
      for (int r = 0; r < 3; r++) begin
         TRIG_LEVEL = 8'($urandom_range(32, 224));
         run_capture("stall_rand", 8'h00, 0, 2, 1'($urandom_range(0, 1)), 1'b1, -1);
      end
      TRIG_LEVEL = 8'h80;
   endtask

   task automatic test_no_trigger();
      TRIG_LEVEL = 8'h80;
      start_capture(8'h10, 0, 1, 1'b1);
      for (int n = 0; n < 1000 * CLK_DIV; n++) begin
         if (n % 97 == 50) ARM = 1'b1;
         tick();
         ARM = 1'b0;
         if (n % 500 == 499) begin
            tests++;
            if (BUSY !== 1'b1 || ADC_nOE !== 1'b0 || RD_VALID !== 1'b0) begin
               fails++;
               $display("FAIL no_trigger_wait got busy=%b noe=%b valid=%b exp 1 0 0", BUSY, ADC_nOE, RD_VALID);
            end
         end
      end
      capturing = 1'b0;
      RST = 1'b1;
      tick();
      RST = 1'b0;
      check_idle_outputs("no_trigger_reset", 1'b0);
   endtask

   task automatic test_reset_mid();
      int n;
      TRIG_LEVEL = 8'h80;
      start_capture(8'h70, 2, 0, 1'b1);
      n = 0;
      while (cap_q.size() < 11 && n < 400) begin tick(); n++; end
      tests++;
      if (cap_q.size() < 11 || ADC_nOE !== 1'b0) begin
         fails++;
         $display("FAIL post_reach got samples=%0d noe=%b exp >=11 and 0", cap_q.size(), ADC_nOE);
      end
      RST = 1'b1;
      tick();
      RST = 1'b0;
      capturing = 1'b0;
      check_idle_outputs("reset_in_post", 1'b0);
      tick();
      start_capture(8'h70, 2, 0, 1'b1);
      n = 0;
      while (rx_q.size() < 5 && n < 400) begin tick(); n++; end
      tests++;
      if (rx_q.size() < 5) begin
         fails++;
         $display("FAIL read_reach got transfers=%0d exp >=5", rx_q.size());
      end
      RST = 1'b1;
      tick();
      RST = 1'b0;
      capturing = 1'b0;
      check_idle_outputs("reset_in_read", 1'b0);
      tick();
      run_capture("after_reset", 8'h70, 2, 0, 1'b1, 1'b0, 8'h80);
   endtask

   initial begin
      test_reset();
      test_ramp_rising();
      test_ramp_falling();
      test_backpressure();
      test_no_trigger();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
